// File: rtl/spi_slave_duplex.sv
// Full-duplex SPI slave with selectable CPOL/CPHA. The pins are oversampled in the clk domain.
// Back-to-back words per CS frame: rx_valid pulses per word, abort pulses per discarded partial word.
module spi_slave_duplex #(
  parameter int BITS        = 32,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0,
  parameter int INV_MOSI    = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            sck,
  input  logic            mosi,
  output logic            miso,
  output logic            miso_oe,
  input  logic [BITS-1:0] tx_data,
  output logic            tx_load,
  output logic [BITS-1:0] rx_data,
  output logic            rx_valid,
  output logic            abort,
  output logic            busy
);
  localparam int              CW          = $clog2(BITS);
  localparam int              TW          = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic            SAMPLE_RISE = (CPOL == CPHA);
  localparam logic            IDLE_SCK    = (CPOL != 0);
  localparam logic            INV         = (INV_MOSI != 0);
  localparam logic            TMO_EN      = (TIMEOUT != 0);
  localparam logic [CW-1:0]   LAST_BIT    = CW'(BITS - 1);
  localparam logic [TW-1:0]   TMO_MAX     = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync, flush;
  logic                   cs_d, sck_d, armed;
  logic                   cs_s, sck_s, mosi_s;
  logic                   cs_fall, cs_rise, sck_rise, sck_fall, any_edge;
  logic                   sample_edge, shift_edge, tmo_hit, mosi_bit;
  logic [CW-1:0]          bit_cnt;
  logic [TW-1:0]          tmo_cnt;
  logic                   pending;
  logic [BITS-1:0]        tx_sh, rx_sh;
  logic                   start, sample, shift, abort_n, word_done;

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign mosi_bit = mosi_s ^ INV;

  // A frame may only start once cs has been seen high after reset, hence the arming flag.
  assign cs_fall     = armed & cs_d & ~cs_s;
  assign cs_rise     = ~cs_d & cs_s;
  assign sck_rise    = sck_s & ~sck_d;
  assign sck_fall    = ~sck_s & sck_d;
  assign any_edge    = sck_s ^ sck_d;
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;
  assign tmo_hit     = TMO_EN & ~any_edge & (tmo_cnt == TMO_MAX);
  assign word_done   = sample & (bit_cnt == LAST_BIT);

  assign busy    = (state != IDLE);
  assign miso_oe = (state == ACTIVE);
  assign miso    = miso_oe & tx_sh[BITS-1];

  // Pin synchronisers, delayed copies for edge detection, and post-reset arming
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync   <= '1;
      sck_sync  <= {SYNC_STAGES{IDLE_SCK}};
      mosi_sync <= '0;
      flush     <= '0;
      cs_d      <= 1'b1;
      sck_d     <= IDLE_SCK;
      armed     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
      cs_d      <= cs_s;
      sck_d     <= sck_s;
      armed     <= armed | (flush[SYNC_STAGES-1] & cs_s);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and per-cycle datapath strobes; cs release outranks timeout and SCK edges
  always_comb begin
    state_n = state;
    start   = 1'b0;
    sample  = 1'b0;
    shift   = 1'b0;
    abort_n = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n = ACTIVE;
          start   = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_n = IDLE;
          abort_n = (bit_cnt != '0);
        end else if (tmo_hit) begin
          state_n = WAIT_CS;
          abort_n = 1'b1;
        end else if (sample_edge) begin
          sample = 1'b1;
        end else if (shift_edge && pending) begin
          shift = 1'b1;
        end else begin
          state_n = ACTIVE;
        end
      end
      WAIT_CS: begin
        if (cs_rise) state_n = IDLE;
        else         state_n = WAIT_CS;
      end
      default: state_n = IDLE;
    endcase
  end

  // Shift registers, bit counter, timeout counter and the registered pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      tmo_cnt  <= '0;
      pending  <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      abort    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      abort    <= abort_n;
      if (start) begin
        bit_cnt <= '0;
        pending <= 1'b0;
        tx_sh   <= tx_data;
        tx_load <= 1'b1;
      end else if (abort_n) begin
        bit_cnt <= '0;
        pending <= 1'b0;
      end else if (sample) begin
        rx_sh <= {rx_sh[BITS-2:0], mosi_bit};
        if (word_done) begin
          // The final bit's shift is dropped: the next word is reloaded with its MSB on the line.
          bit_cnt  <= '0;
          pending  <= 1'b0;
          rx_data  <= {rx_sh[BITS-2:0], mosi_bit};
          rx_valid <= 1'b1;
          tx_sh    <= tx_data;
          tx_load  <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
          pending <= 1'b1;
        end
      end else if (shift) begin
        tx_sh   <= {tx_sh[BITS-2:0], 1'b0};
        pending <= 1'b0;
      end else begin
        pending <= pending;
      end
      if (start || state != ACTIVE || any_edge) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX)               tmo_cnt <= tmo_cnt + TW'(1);
      else                                       tmo_cnt <= tmo_cnt;
    end
  end

endmodule
